// File: rtl/alu_pkg.sv
// alu_pkg: constants shared by the ALU issue stage, the execution units and
// the result collector.
//   UNIT_*      2-bit unit select codes (REQ_FUN[3:2])
//   *_W         field widths of the request function code
//   unit_onehot maps a unit select to the {shift, cmp, logic, arith} enables
package alu_pkg;

  localparam int REQ_FUN_W = 4;
  localparam int UNIT_W    = 2;
  localparam int FUN_W     = 2;
  localparam int N_UNITS   = 4;

  localparam logic [UNIT_W-1:0] UNIT_ARITH = 2'b00;
  localparam logic [UNIT_W-1:0] UNIT_LOGIC = 2'b01;
  localparam logic [UNIT_W-1:0] UNIT_CMP   = 2'b10;
  localparam logic [UNIT_W-1:0] UNIT_SHIFT = 2'b11;

  // Bit order of the returned vector: [3]=shift, [2]=cmp, [1]=logic, [0]=arith.
  function automatic logic [N_UNITS-1:0] unit_onehot(input logic [UNIT_W-1:0] unit);
    logic [N_UNITS-1:0] oh;
    oh = '0;
    case (unit)
      UNIT_ARITH: oh[0] = 1'b1;
      UNIT_LOGIC: oh[1] = 1'b1;
      UNIT_CMP:   oh[2] = 1'b1;
      UNIT_SHIFT: oh[3] = 1'b1;
      default:    oh    = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// alu_issue_fifo: synchronous FIFO buffering issue requests.
// Ports:
//   clk_i, rst_i      clock and synchronous active-high reset
//   push_i, wdata_i   write request and payload (ignored while full)
//   pop_i, rdata_o    read request (ignored while empty); rdata_o shows the head
//   full_o, empty_o   occupancy flags derived from the registered count
//   count_o           current occupancy, 0..DEPTH
module alu_issue_fifo
  import alu_pkg::*;
#(
  parameter int WIDTH     = 36,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic                 pop_i,
  output logic [WIDTH-1:0]     rdata_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [CNT_WIDTH-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 push_eff;
  logic                 pop_eff;

  assign full_o  = (count_q == CNT_WIDTH'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_eff = push_i && !full_o;
  assign pop_eff  = pop_i && !empty_o;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_eff) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_eff)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_eff, pop_eff})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push_eff) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_op_issue.sv
// alu_op_issue: issue stage of the signed 16-bit ALU.
// Buffers requests in alu_issue_fifo, pops one per cycle while HOLD is low,
// drives registered operands, function code and one-hot unit enables, and
// flags RES_Valid/RES_Unit one cycle after each issue, when the selected
// unit's output register holds the result.
// Ports:
//   CLK, rst                 clock, synchronous active-high reset
//   REQ_Valid/REQ_Ready      request handshake; REQ_A, REQ_B, REQ_FUN payload
//   HOLD                     downstream stall, blocks issue only
//   A, B, ALU_FUN            registered operands and unit function
//   *_Enable                 registered one-hot unit enables
//   RES_Valid, RES_Unit      result-present flag and its unit select
//   FIFO_Count               request buffer occupancy
// Build option: define ALU_ISSUE_BYPASS_EN to let a request arriving at an
// empty, unstalled buffer issue on the edge it is accepted.
module alu_op_issue
  import alu_pkg::*;
#(
  parameter int IN_DATA_WIDTH = 16,
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_WIDTH     = 3
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic                     REQ_Valid,
  output logic                     REQ_Ready,
  input  logic [IN_DATA_WIDTH-1:0] REQ_A,
  input  logic [IN_DATA_WIDTH-1:0] REQ_B,
  input  logic [REQ_FUN_W-1:0]     REQ_FUN,
  input  logic                     HOLD,
  output logic [IN_DATA_WIDTH-1:0] A,
  output logic [IN_DATA_WIDTH-1:0] B,
  output logic [FUN_W-1:0]         ALU_FUN,
  output logic                     Arith_Enable,
  output logic                     Logic_Enable,
  output logic                     CMP_Enable,
  output logic                     SHIFT_Enable,
  output logic                     RES_Valid,
  output logic [UNIT_W-1:0]        RES_Unit,
  output logic [CNT_WIDTH-1:0]     FIFO_Count
);

  localparam int PAYLOAD_W = 2 * IN_DATA_WIDTH + REQ_FUN_W;

  logic [PAYLOAD_W-1:0]     req_payload;
  logic [PAYLOAD_W-1:0]     head_payload;
  logic [PAYLOAD_W-1:0]     issue_payload;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     take_req;
  logic                     bypass;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     issue;

  logic [IN_DATA_WIDTH-1:0] a_q, a_d;
  logic [IN_DATA_WIDTH-1:0] b_q, b_d;
  logic [FUN_W-1:0]         fun_q, fun_d;
  logic [UNIT_W-1:0]        unit_q, unit_d;
  logic [N_UNITS-1:0]       en_q, en_d;
  logic                     res_valid_q, res_valid_d;
  logic [UNIT_W-1:0]        res_unit_q, res_unit_d;

  assign req_payload = {REQ_A, REQ_B, REQ_FUN};

  // Ready comes from the registered count only; a pop in the same cycle does
  // not create room for a push.
  assign REQ_Ready = !fifo_full && !rst;
  assign take_req  = REQ_Valid && REQ_Ready;

`ifdef ALU_ISSUE_BYPASS_EN
  assign bypass = take_req && fifo_empty && !HOLD;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push     = take_req && !bypass;
  assign fifo_pop      = !HOLD && !fifo_empty;
  assign issue         = fifo_pop || bypass;
  assign issue_payload = bypass ? req_payload : head_payload;

  alu_issue_fifo #(
    .WIDTH     (PAYLOAD_W),
    .DEPTH     (FIFO_DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .wdata_i (req_payload),
    .pop_i   (fifo_pop),
    .rdata_o (head_payload),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (FIFO_Count)
  );

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    fun_d  = fun_q;
    unit_d = unit_q;
    en_d   = '0;
    if (issue) begin
      a_d    = issue_payload[PAYLOAD_W-1 -: IN_DATA_WIDTH];
      b_d    = issue_payload[REQ_FUN_W +: IN_DATA_WIDTH];
      fun_d  = issue_payload[FUN_W-1:0];
      unit_d = issue_payload[REQ_FUN_W-1 -: UNIT_W];
      en_d   = unit_onehot(issue_payload[REQ_FUN_W-1 -: UNIT_W]);
    end
    // The unit registers its result on the edge after the enable, so the
    // valid flag is the enable delayed by one stage.
    res_valid_d = |en_q;
    res_unit_d  = unit_q;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      fun_q       <= '0;
      unit_q      <= '0;
      en_q        <= '0;
      res_valid_q <= 1'b0;
      res_unit_q  <= '0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      fun_q       <= fun_d;
      unit_q      <= unit_d;
      en_q        <= en_d;
      res_valid_q <= res_valid_d;
      res_unit_q  <= res_unit_d;
    end
  end

  assign A            = a_q;
  assign B            = b_q;
  assign ALU_FUN      = fun_q;
  assign Arith_Enable = en_q[0];
  assign Logic_Enable = en_q[1];
  assign CMP_Enable   = en_q[2];
  assign SHIFT_Enable = en_q[3];
  assign RES_Valid    = res_valid_q;
  assign RES_Unit     = res_unit_q;

endmodule

// File: tb/tb_alu_op_issue.sv
module tb_alu_op_issue;

  logic        CLK = 1'b0;
  logic        rst;
  logic        REQ_Valid;
  logic        REQ_Ready;
  logic [15:0] REQ_A, REQ_B;
  logic [3:0]  REQ_FUN;
  logic        HOLD;
  logic [15:0] A, B;
  logic [1:0]  ALU_FUN;
  logic        Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable;
  logic        RES_Valid;
  logic [1:0]  RES_Unit;
  logic [2:0]  FIFO_Count;
  logic [3:0]  en;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef ALU_ISSUE_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  always #5 CLK = ~CLK;

  assign en = {SHIFT_Enable, CMP_Enable, Logic_Enable, Arith_Enable};

  alu_op_issue #(.IN_DATA_WIDTH(16), .FIFO_DEPTH(4), .CNT_WIDTH(3)) dut (
    .CLK(CLK), .rst(rst), .REQ_Valid(REQ_Valid), .REQ_Ready(REQ_Ready),
    .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_FUN(REQ_FUN), .HOLD(HOLD),
    .A(A), .B(B), .ALU_FUN(ALU_FUN),
    .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
    .CMP_Enable(CMP_Enable), .SHIFT_Enable(SHIFT_Enable),
    .RES_Valid(RES_Valid), .RES_Unit(RES_Unit), .FIFO_Count(FIFO_Count)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; REQ_Valid = 1'b0; HOLD = 1'b0;
    REQ_A = '0; REQ_B = '0; REQ_FUN = '0;
    tick; tick;
    n_tests++; if (FIFO_Count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", FIFO_Count); end
    n_tests++; if (en !== 4'b0000) begin n_fail++; $display("FAIL reset_en got %b exp 0000", en); end
    n_tests++; if (RES_Valid !== 1'b0 || RES_Unit !== 2'd0) begin n_fail++; $display("FAIL reset_res got %b/%0d exp 0/0", RES_Valid, RES_Unit); end
    n_tests++; if (A !== 16'd0 || B !== 16'd0 || ALU_FUN !== 2'd0) begin n_fail++; $display("FAIL reset_regs got %0h/%0h/%0h exp 0", A, B, ALU_FUN); end
    n_tests++; if (REQ_Ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", REQ_Ready); end
    rst = 1'b0;
    #1;
    n_tests++; if (REQ_Ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset got %b exp 1", REQ_Ready); end
  endtask

  task automatic test_single;
    logic [3:0] exp_en;
    logic       exp_rv;
    REQ_Valid = 1'b1; REQ_A = 16'd5; REQ_B = 16'd5; REQ_FUN = 4'b1001; HOLD = 1'b0;
    tick;
    REQ_Valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      exp_en = (c == 1 - BYP) ? 4'b0100 : 4'b0000;
      exp_rv = (c == 2 - BYP);
      n_tests++; if (en !== exp_en) begin n_fail++; $display("FAIL single_en c=%0d got %b exp %b", c, en, exp_en); end
      n_tests++; if (RES_Valid !== exp_rv) begin n_fail++; $display("FAIL single_rv c=%0d got %b exp %b", c, RES_Valid, exp_rv); end
      if (c == 1 - BYP) begin
        n_tests++; if (ALU_FUN !== 2'b01 || A !== 16'd5 || B !== 16'd5) begin n_fail++; $display("FAIL single_ops got fun=%b A=%0d B=%0d exp 01/5/5", ALU_FUN, A, B); end
      end
      if (exp_rv) begin
        n_tests++; if (RES_Unit !== 2'b10) begin n_fail++; $display("FAIL single_unit got %b exp 10", RES_Unit); end
      end
      tick;
    end
  endtask

  task automatic test_hold_fill;
    logic [15:0] oa [4];
    logic [15:0] ob [4];
    logic [3:0]  of [4];
    logic [3:0]  exp_en;
    oa = '{16'd10, 16'd20, 16'd30, 16'd40};
    ob = '{16'd1, 16'd2, 16'd3, 16'd4};
    of = '{4'b0000, 4'b0101, 4'b1010, 4'b1111};
    HOLD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      REQ_Valid = 1'b1; REQ_A = oa[i]; REQ_B = ob[i]; REQ_FUN = of[i];
      #1;
      n_tests++; if (REQ_Ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready i=%0d got %b exp 1", i, REQ_Ready); end
      tick;
    end
    REQ_A = 16'd99; REQ_B = 16'd99; REQ_FUN = 4'b0000;
    n_tests++; if (FIFO_Count !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d exp 4", FIFO_Count); end
    n_tests++; if (REQ_Ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b exp 0", REQ_Ready); end
    n_tests++; if (en !== 4'b0000) begin n_fail++; $display("FAIL hold_en got %b exp 0000", en); end
    tick;
    n_tests++; if (FIFO_Count !== 3'd4) begin n_fail++; $display("FAIL full_drop got %0d exp 4", FIFO_Count); end
    REQ_Valid = 1'b0; HOLD = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      exp_en = 4'b0001 << of[i][3:2];
      n_tests++; if (en !== exp_en) begin n_fail++; $display("FAIL drain_en i=%0d got %b exp %b", i, en, exp_en); end
      n_tests++; if (A !== oa[i] || B !== ob[i] || ALU_FUN !== of[i][1:0]) begin n_fail++; $display("FAIL drain_ops i=%0d got %0d/%0d/%b exp %0d/%0d/%b", i, A, B, ALU_FUN, oa[i], ob[i], of[i][1:0]); end
      n_tests++; if (FIFO_Count !== 3'(3 - i)) begin n_fail++; $display("FAIL drain_count i=%0d got %0d exp %0d", i, FIFO_Count, 3 - i); end
      if (i > 0) begin
        n_tests++; if (RES_Valid !== 1'b1 || RES_Unit !== of[i-1][3:2]) begin n_fail++; $display("FAIL drain_res i=%0d got %b/%0d exp 1/%0d", i, RES_Valid, RES_Unit, of[i-1][3:2]); end
      end
    end
    tick;
    n_tests++; if (en !== 4'b0000 || A !== 16'd40 || ALU_FUN !== 2'b11) begin n_fail++; $display("FAIL drain_idle got en=%b A=%0d fun=%b exp 0000/40/11", en, A, ALU_FUN); end
    n_tests++; if (RES_Valid !== 1'b1 || RES_Unit !== 2'b11) begin n_fail++; $display("FAIL drain_last_res got %b/%0d exp 1/3", RES_Valid, RES_Unit); end
    tick;
    n_tests++; if (RES_Valid !== 1'b0) begin n_fail++; $display("FAIL drain_rv_end got %b exp 0", RES_Valid); end
  endtask

  task automatic test_back_to_back;
    int         issued;
    logic [3:0] ef;
    logic [3:0] exp_en;
    issued = 0;
    HOLD = 1'b0;
    for (int i = 0; i < 26; i++) begin
      if (i < 20) begin
        REQ_Valid = 1'b1; REQ_A = 16'(i * 7 + 1); REQ_B = 16'(i + 100); REQ_FUN = 4'(i);
        #1;
        n_tests++; if (REQ_Ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready i=%0d got %b exp 1", i, REQ_Ready); end
      end else begin
        REQ_Valid = 1'b0;
      end
      tick;
      if (en !== 4'b0000 && issued < 20) begin
        ef = 4'(issued);
        exp_en = 4'b0001 << ef[3:2];
        n_tests++; if (en !== exp_en || A !== 16'(issued * 7 + 1) || B !== 16'(issued + 100) || ALU_FUN !== ef[1:0]) begin
          n_fail++; $display("FAIL stream_op n=%0d got en=%b A=%0d B=%0d fun=%b exp en=%b A=%0d", issued, en, A, B, ALU_FUN, exp_en, issued * 7 + 1);
        end
        issued++;
      end
      if (i < 20) begin
        n_tests++; if (issued !== i + BYP) begin n_fail++; $display("FAIL stream_rate i=%0d got %0d issued exp %0d", i, issued, i + BYP); end
        n_tests++; if (FIFO_Count !== 3'(1 - BYP)) begin n_fail++; $display("FAIL stream_count i=%0d got %0d exp %0d", i, FIFO_Count, 1 - BYP); end
      end
    end
    n_tests++; if (issued !== 20) begin n_fail++; $display("FAIL stream_total got %0d exp 20", issued); end
    n_tests++; if (FIFO_Count !== 3'd0 || en !== 4'b0000) begin n_fail++; $display("FAIL stream_idle got count=%0d en=%b exp 0/0000", FIFO_Count, en); end
  endtask

  task automatic test_reset_midop;
    HOLD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      REQ_Valid = 1'b1; REQ_A = 16'(200 + i); REQ_B = 16'(i); REQ_FUN = 4'(i << 2);
      tick;
    end
    REQ_Valid = 1'b0; HOLD = 1'b0;
    tick;
    n_tests++; if (en !== 4'b0001 || A !== 16'd200 || FIFO_Count !== 3'd3) begin n_fail++; $display("FAIL midop_setup got en=%b A=%0d count=%0d exp 0001/200/3", en, A, FIFO_Count); end
    rst = 1'b1;
    #1;
    n_tests++; if (REQ_Ready !== 1'b0) begin n_fail++; $display("FAIL midop_ready got %b exp 0", REQ_Ready); end
    tick;
    n_tests++; if (FIFO_Count !== 3'd0 || en !== 4'b0000 || RES_Valid !== 1'b0) begin n_fail++; $display("FAIL midop_reset got count=%0d en=%b rv=%b exp 0/0000/0", FIFO_Count, en, RES_Valid); end
    n_tests++; if (A !== 16'd0) begin n_fail++; $display("FAIL midop_A got %0d exp 0", A); end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick;
      n_tests++; if (en !== 4'b0000 || RES_Valid !== 1'b0 || FIFO_Count !== 3'd0) begin n_fail++; $display("FAIL midop_quiet c=%0d got en=%b rv=%b count=%0d exp 0", c, en, RES_Valid, FIFO_Count); end
    end
  endtask

  task automatic test_units;
    logic [1:0] u;
    logic [1:0] f;
    logic [3:0] exp_en;
    HOLD = 1'b0;
    for (int k = 0; k < 4; k++) begin
      u = 2'(k); f = 2'(3 - k);
      REQ_Valid = 1'b1; REQ_A = 16'(k); REQ_B = 16'hFFFF; REQ_FUN = {u, f};
      tick;
      REQ_Valid = 1'b0;
      for (int c = 0; c < 1 - BYP; c++) tick;
      exp_en = 4'b0001 << u;
      n_tests++; if (en !== exp_en || ALU_FUN !== f) begin n_fail++; $display("FAIL unit_en u=%0d got en=%b fun=%b exp %b/%b", u, en, ALU_FUN, exp_en, f); end
      tick;
      n_tests++; if (RES_Valid !== 1'b1 || RES_Unit !== u) begin n_fail++; $display("FAIL unit_res u=%0d got %b/%0d exp 1/%0d", u, RES_Valid, RES_Unit, u); end
      tick;
    end
  endtask

`ifdef ALU_ISSUE_BYPASS_EN
  task automatic test_bypass;
    HOLD = 1'b0;
    REQ_Valid = 1'b1; REQ_A = 16'd77; REQ_B = 16'd3; REQ_FUN = 4'b1100;
    tick;
    REQ_Valid = 1'b0;
    n_tests++; if (en !== 4'b1000 || A !== 16'd77 || FIFO_Count !== 3'd0) begin n_fail++; $display("FAIL bypass_issue got en=%b A=%0d count=%0d exp 1000/77/0", en, A, FIFO_Count); end
    tick;
    n_tests++; if (RES_Valid !== 1'b1 || RES_Unit !== 2'b11 || en !== 4'b0000) begin n_fail++; $display("FAIL bypass_res got %b/%0d en=%b exp 1/3/0000", RES_Valid, RES_Unit, en); end
    HOLD = 1'b1;
    REQ_Valid = 1'b1; REQ_A = 16'd88; REQ_FUN = 4'b0110;
    tick;
    REQ_Valid = 1'b0;
    n_tests++; if (en !== 4'b0000 || FIFO_Count !== 3'd1) begin n_fail++; $display("FAIL bypass_hold got en=%b count=%0d exp 0000/1", en, FIFO_Count); end
    HOLD = 1'b0;
    tick;
    n_tests++; if (en !== 4'b0010 || A !== 16'd88) begin n_fail++; $display("FAIL bypass_fifo got en=%b A=%0d exp 0010/88", en, A); end
    tick;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_single;
    test_hold_fill;
    test_back_to_back;
    test_reset_midop;
    test_units;
`ifdef ALU_ISSUE_BYPASS_EN
    test_bypass;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
